// File: rtl/ln_norm_pkg.sv
// Shared types and defaults for the current-linearizer / voltage-normalizer sequencer.
package ln_norm_pkg;

  localparam int unsigned DefP      = 32;
  localparam int unsigned DefTmoW   = 12;
  localparam int unsigned DefTmoMax = 4000;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClr   = 3'd1,
    StStart = 3'd2,
    StWait  = 3'd3,
    StDone  = 3'd4,
    StErr   = 3'd5
  } seq_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ln_seq_watchdog.sv
// Loadable watchdog counter: clear has priority over load, load over count.
// expired_o is high while the count equals Limit; the count holds there.
module ln_seq_watchdog #(
  parameter int unsigned Width = 12,
  parameter int unsigned Limit = 4000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == Width'(Limit));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ln_norm_sequencer.sv
// Sequencer for the I/V conversion chains: accept, reset, start, wait for both ACKs, report.
// Optional statistics counters are built when LN_SEQ_STATS_EN is defined.
module ln_norm_sequencer
  import ln_norm_pkg::*;
#(
  parameter int unsigned P       = DefP,
  parameter int unsigned TMO_W   = DefTmoW,
  parameter int unsigned TMO_MAX = DefTmoMax
) (
  input  logic         CLK,
  input  logic         RST_N,
`ifdef LN_SEQ_STATS_EN
  output logic [15:0]  SAMPLE_CNT,
  output logic [15:0]  TMO_CNT,
`endif
  input  logic         SAMPLE_VALID,
  output logic         SAMPLE_READY,
  input  logic [P-1:0] I_IN,
  input  logic [P-1:0] V_IN,
  output logic [P-1:0] I_OUT,
  output logic [P-1:0] V_OUT,
  output logic         RST_FSM_OUT,
  output logic         BEGIN_I,
  output logic         BEGIN_V,
  input  logic         ACK_I,
  input  logic         ACK_V,
  input  logic [P-1:0] RESULT_I_IN,
  input  logic [P-1:0] RESULT_V_IN,
  output logic [P-1:0] RESULT_I,
  output logic [P-1:0] RESULT_V,
  output logic         RESULT_VALID,
  output logic         TIMEOUT,
  output logic         BUSY
);

  seq_state_e state_q, state_d;
  logic       ack_i_seen_q, ack_i_seen_d;
  logic       ack_v_seen_q, ack_v_seen_d;
  logic       retry_q, retry_d;
  logic [P-1:0] op_i_q, op_v_q, res_i_q, res_i_d, res_v_q, res_v_d;
  logic       accept;
  logic       wd_clr, wd_en, wd_expired;

  ln_seq_watchdog #(
    .Width (TMO_W),
    .Limit (TMO_MAX)
  ) u_watchdog (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .clr_i      (wd_clr),
    .load_i     (1'b0),
    .load_val_i ({TMO_W{1'b0}}),
    .en_i       (wd_en),
    .expired_o  (wd_expired)
  );

  assign accept   = (state_q == StIdle) && SAMPLE_VALID;
  assign I_OUT    = op_i_q;
  assign V_OUT    = op_v_q;
  assign RESULT_I = res_i_q;
  assign RESULT_V = res_v_q;
  assign BUSY     = (state_q != StIdle);

  always_comb begin
    state_d      = state_q;
    ack_i_seen_d = ack_i_seen_q;
    ack_v_seen_d = ack_v_seen_q;
    retry_d      = retry_q;
    res_i_d      = res_i_q;
    res_v_d      = res_v_q;
    wd_clr       = 1'b0;
    wd_en        = 1'b0;
    SAMPLE_READY = 1'b0;
    RST_FSM_OUT  = 1'b0;
    BEGIN_I      = 1'b0;
    BEGIN_V      = 1'b0;
    RESULT_VALID = 1'b0;
    TIMEOUT      = 1'b0;
    unique case (state_q)
      StIdle: begin
        SAMPLE_READY = 1'b1;
        if (SAMPLE_VALID) begin
          retry_d = 1'b0;
          state_d = StClr;
        end
      end
      StClr: begin
        RST_FSM_OUT  = 1'b1;
        ack_i_seen_d = 1'b0;
        ack_v_seen_d = 1'b0;
        wd_clr       = 1'b1;
        state_d      = StStart;
      end
      StStart: begin
        BEGIN_I = 1'b1;
        BEGIN_V = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        BEGIN_I = !ack_i_seen_q;
        BEGIN_V = !ack_v_seen_q;
        wd_en   = 1'b1;
        // Only the first ACK of a run captures; later (sticky) ACKs leave the result alone.
        if (ACK_I && !ack_i_seen_q) begin
          ack_i_seen_d = 1'b1;
          res_i_d      = RESULT_I_IN;
        end
        if (ACK_V && !ack_v_seen_q) begin
          ack_v_seen_d = 1'b1;
          res_v_d      = RESULT_V_IN;
        end
        if (ack_i_seen_d && ack_v_seen_d) begin
          state_d = StDone;
        end else if (wd_expired) begin
          state_d = StErr;
        end
      end
      StDone: begin
        RESULT_VALID = 1'b1;
        state_d      = StIdle;
      end
      StErr: begin
        TIMEOUT = 1'b1;
        if (retry_q) begin
          state_d = StIdle;
        end else begin
          retry_d = 1'b1;
          state_d = StClr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      ack_i_seen_q <= 1'b0;
      ack_v_seen_q <= 1'b0;
      retry_q      <= 1'b0;
      op_i_q       <= '0;
      op_v_q       <= '0;
      res_i_q      <= '0;
      res_v_q      <= '0;
    end else begin
      state_q      <= state_d;
      ack_i_seen_q <= ack_i_seen_d;
      ack_v_seen_q <= ack_v_seen_d;
      retry_q      <= retry_d;
      res_i_q      <= res_i_d;
      res_v_q      <= res_v_d;
      if (accept) begin
        op_i_q <= I_IN;
        op_v_q <= V_IN;
      end
    end
  end

`ifdef LN_SEQ_STATS_EN
  logic [15:0] sample_cnt_q, tmo_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sample_cnt_q <= 16'd0;
      tmo_cnt_q    <= 16'd0;
    end else begin
      if (state_q == StDone) sample_cnt_q <= sat_inc16(sample_cnt_q);
      if (state_q == StErr)  tmo_cnt_q    <= sat_inc16(tmo_cnt_q);
    end
  end

  assign SAMPLE_CNT = sample_cnt_q;
  assign TMO_CNT    = tmo_cnt_q;
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_ln_norm_sequencer.sv
// Scoreboard bench for ln_norm_sequencer: directed runs push expected strobes, a monitor checks them.
module tb_ln_norm_sequencer;

  localparam int unsigned TmoMax = 20;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        SAMPLE_VALID = 1'b0;
  logic        SAMPLE_READY;
  logic [31:0] I_IN = '0, V_IN = '0;
  logic [31:0] I_OUT, V_OUT;
  logic        RST_FSM_OUT, BEGIN_I, BEGIN_V;
  logic        ACK_I = 1'b0, ACK_V = 1'b0;
  logic [31:0] RESULT_I_IN = '0, RESULT_V_IN = '0;
  logic [31:0] RESULT_I, RESULT_V;
  logic        RESULT_VALID, TIMEOUT, BUSY;
`ifdef LN_SEQ_STATS_EN
  logic [15:0] SAMPLE_CNT, TMO_CNT;
`endif

  ln_norm_sequencer #(
    .P       (32),
    .TMO_W   (12),
    .TMO_MAX (TmoMax)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
`ifdef LN_SEQ_STATS_EN
    .SAMPLE_CNT   (SAMPLE_CNT),
    .TMO_CNT      (TMO_CNT),
`endif
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE_READY (SAMPLE_READY),
    .I_IN         (I_IN),
    .V_IN         (V_IN),
    .I_OUT        (I_OUT),
    .V_OUT        (V_OUT),
    .RST_FSM_OUT  (RST_FSM_OUT),
    .BEGIN_I      (BEGIN_I),
    .BEGIN_V      (BEGIN_V),
    .ACK_I        (ACK_I),
    .ACK_V        (ACK_V),
    .RESULT_I_IN  (RESULT_I_IN),
    .RESULT_V_IN  (RESULT_V_IN),
    .RESULT_I     (RESULT_I),
    .RESULT_V     (RESULT_V),
    .RESULT_VALID (RESULT_VALID),
    .TIMEOUT      (TIMEOUT),
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_tmo;
    int          cyc;
    logic [31:0] ri;
    logic [31:0] rv;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_err = 0, cyc = 0;
  int          dly_i = -1, dly_v = -1, cnt_i = 0, cnt_v = 0;
  bit          sticky_i = 1'b0;
  logic [31:0] model_ri = '0, model_rv = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask

  // Chain model: ACK goes high d cycles after the first BEGIN cycle; d < 0 means never.
  initial forever begin
    step();
    if (BEGIN_I) begin
      if (cnt_i == dly_i) ACK_I = 1'b1;
      else if (!sticky_i) ACK_I = 1'b0;
      cnt_i++;
    end else begin
      cnt_i = 0;
      if (!sticky_i) ACK_I = 1'b0;
    end
    if (BEGIN_V) begin
      ACK_V = (cnt_v == dly_v);
      cnt_v++;
    end else begin
      cnt_v = 0;
      ACK_V = 1'b0;
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (RST_N && (RESULT_VALID || TIMEOUT)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL stray_strobe: got valid=%b timeout=%b at cycle %0d, expected none",
                 RESULT_VALID, TIMEOUT, cyc);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind", 32'(TIMEOUT), 32'(e.is_tmo));
        chk("strobe_cycle", cyc, e.cyc);
        chk("result_i", RESULT_I, e.ri);
        chk("result_v", RESULT_V, e.rv);
      end
    end
  end

  task automatic start_sample(input logic [31:0] i, v, ri, rv, input int di, dv, input bit hold,
                              output int a);
    int m;
    I_IN = i;
    V_IN = v;
    RESULT_I_IN = ri;
    RESULT_V_IN = rv;
    dly_i = di;
    dly_v = dv;
    SAMPLE_VALID = 1'b1;
    for (int k = 0; k < 200 && !SAMPLE_READY; k++) step();
    if (!SAMPLE_READY) chk("ready_wait_bound", 32'(SAMPLE_READY), 32'd1);
    step();
    a = cyc;
    if (!hold) SAMPLE_VALID = 1'b0;
    chk("i_out_load", I_OUT, i);
    chk("v_out_load", V_OUT, v);
    if (di >= 0 && dv >= 0) begin
      m = (di > dv) ? di : dv;
      model_ri = ri;
      model_rv = rv;
      sb.push_back('{1'b0, a + 2 + m, ri, rv});
    end else begin
      if (di >= 0) model_ri = ri;
      if (dv >= 0) model_rv = rv;
      sb.push_back('{1'b1, a + TmoMax + 3, model_ri, model_rv});
      sb.push_back('{1'b1, a + 2 * TmoMax + 7, model_ri, model_rv});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: bench did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int a, b;
    #1;
    chk("rst_ready", 32'(SAMPLE_READY), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_begin", {30'd0, BEGIN_I, BEGIN_V}, 32'd0);
    chk("rst_strobes", {29'd0, RST_FSM_OUT, RESULT_VALID, TIMEOUT}, 32'd0);
    chk("rst_i_out", I_OUT, 32'd0);
    chk("rst_result_i", RESULT_I, 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Nominal run
    start_sample(32'h40A00000, 32'h41200000, 32'h00050000, 32'h000A0000, 10, 6, 1'b0, a);
    chk("nom_rst_fsm", 32'(RST_FSM_OUT), 32'd1);
    chk("nom_ready_low", 32'(SAMPLE_READY), 32'd0);
    step();
    chk("nom_rst_fsm_once", 32'(RST_FSM_OUT), 32'd0);
    chk("nom_begin", {30'd0, BEGIN_I, BEGIN_V}, 32'd3);
    wait_cyc(a + 8);
    chk("nom_begin_v_first", {30'd0, BEGIN_I, BEGIN_V}, 32'd2);
    wait_cyc(a + 13);
    chk("nom_idle_ready", 32'(SAMPLE_READY), 32'd1);

    // Both ACKs in the same WAIT cycle
    start_sample(32'h3F800000, 32'h3F000000, 32'h11111111, 32'h22222222, 5, 5, 1'b0, a);
    wait_cyc(a + 8);

    // ACK_V never returns: timeout, replay, second timeout drops the sample
    start_sample(32'h40400000, 32'h40800000, 32'h33333333, 32'hDEADBEEF, 3, -1, 1'b0, a);
    wait_cyc(a + 24);
    chk("tmo_replay_rst", 32'(RST_FSM_OUT), 32'd1);
    chk("tmo_replay_i_out", I_OUT, 32'h40400000);
    chk("tmo_replay_v_out", V_OUT, 32'h40800000);
    step();
    chk("tmo_replay_begin", {30'd0, BEGIN_I, BEGIN_V}, 32'd3);
    wait_cyc(a + 48);
    chk("tmo_drop_ready", 32'(SAMPLE_READY), 32'd1);
    chk("tmo_drop_busy", 32'(BUSY), 32'd0);

    // Back-to-back with SAMPLE_VALID held and a sticky ACK_I
    sticky_i = 1'b1;
    start_sample(32'h3F800000, 32'h40000000, 32'h44444444, 32'h55555555, 10, 6, 1'b1, a);
    I_IN = 32'h40400000;
    V_IN = 32'h40800000;
    wait_cyc(a + 12);
    chk("b2b_no_early_ready", 32'(SAMPLE_READY), 32'd0);
    step();
    chk("b2b_idle_ready", 32'(SAMPLE_READY), 32'd1);
    chk("b2b_hold_i_out", I_OUT, 32'h3F800000);
    step();
    b = cyc;
    SAMPLE_VALID = 1'b0;
    RESULT_I_IN = 32'h66666666;
    RESULT_V_IN = 32'h77777777;
    chk("b2b_second_accept", 32'(RST_FSM_OUT), 32'd1);
    chk("b2b_i_out", I_OUT, 32'h40400000);
    model_ri = 32'h66666666;
    model_rv = 32'h77777777;
    sb.push_back('{1'b0, b + 8, model_ri, model_rv});
    wait_cyc(b + 2);
    chk("sticky_ignored_begin_i", 32'(BEGIN_I), 32'd1);
    step();
    chk("sticky_seen_in_wait", 32'(BEGIN_I), 32'd0);
    wait_cyc(b + 9);
    sticky_i = 1'b0;
    step();

    // Asynchronous reset mid-WAIT
    start_sample(32'h41000000, 32'h41100000, 32'h88888888, 32'h99999999, -1, -1, 1'b0, a);
    wait_cyc(a + 6);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    sb.delete();
    model_ri = '0;
    model_rv = '0;
    chk("arst_ready", 32'(SAMPLE_READY), 32'd1);
    chk("arst_busy", 32'(BUSY), 32'd0);
    chk("arst_begin", {30'd0, BEGIN_I, BEGIN_V}, 32'd0);
    chk("arst_i_out", I_OUT, 32'd0);
    chk("arst_result_i", RESULT_I, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (30) step();
    chk("arst_idle_after", 32'(SAMPLE_READY), 32'd1);

`ifdef LN_SEQ_STATS_EN
    chk("stats_rst_samples", 32'(SAMPLE_CNT), 32'd0);
    for (int n = 0; n < 3; n++) begin
      start_sample(32'h3F800000 + 32'(n), 32'h40000000, 32'h1000 + 32'(n), 32'h2000, 2, 3, 1'b0, a);
      wait_cyc(a + 6);
    end
    start_sample(32'h40000000, 32'h40000000, 32'h3000, 32'h4000, -1, 4, 1'b0, a);
    wait_cyc(a + 49);
    chk("stats_samples", 32'(SAMPLE_CNT), 32'd3);
    chk("stats_timeouts", 32'(TMO_CNT), 32'd2);
`endif

    repeat (3) step();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ln_norm_sequencer.md
Name: ln_norm_sequencer

Overview:
- Sequencer for the current-linearizer / voltage-normalizer datapath.
- Accepts one (I, V) float sample pair via valid/ready and holds the operands stable.
- Issues FSM-reset and begin strobes to both conversion chains and waits for both ACK_I and ACK_V, under a watchdog.
- Presents the two fixed-point results as one coherent pair with a single-cycle valid.

Parameters:
- P, 32, operand and result width.
- TMO_W, 12, width of the watchdog counter.
- TMO_MAX, 4000, cycles allowed in WAIT before timeout; must be < 2^TMO_W.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- SAMPLE_VALID  in  1  upstream sample pair available.
- SAMPLE_READY  out  1  sequencer can accept a pair.
- I_IN  in  P  current sample, IEEE-754 single.
- V_IN  in  P  voltage sample, IEEE-754 single.
- I_OUT  out  P  registered current operand to the datapath.
- V_OUT  out  P  registered voltage operand to the datapath.
- RST_FSM_OUT  out  1  datapath FSM reset strobe.
- BEGIN_I  out  1  start current chain.
- BEGIN_V  out  1  start voltage chain.
- ACK_I  in  1  current chain done.
- ACK_V  in  1  voltage chain done.
- RESULT_I_IN  in  P  current chain result.
- RESULT_V_IN  in  P  voltage chain result.
- RESULT_I  out  P  latched current result.
- RESULT_V  out  P  latched voltage result.
- RESULT_VALID  out  1  one-cycle strobe: pair valid.
- TIMEOUT  out  1  one-cycle strobe: watchdog expired.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state = IDLE.
  - All outputs 0, except SAMPLE_READY = 1.
  - Watchdog counter and ACK-seen flags cleared.
- SAMPLE_READY = 1 only in IDLE.
- Handshake: a sample is accepted on the rising edge where SAMPLE_VALID && SAMPLE_READY.
  - I_OUT/V_OUT load from I_IN/V_IN on that edge and hold until the next accept.
- States:
  - IDLE: on accept -> CLR.
  - CLR: RST_FSM_OUT = 1 for exactly one cycle; clear ack_i_seen, ack_v_seen and the counter -> START.
  - START: BEGIN_I = BEGIN_V = 1 -> WAIT.
  - WAIT:
    - BEGIN_I stays high until ack_i_seen; BEGIN_V stays high until ack_v_seen.
    - On ACK_I high: set ack_i_seen and capture RESULT_I_IN into RESULT_I, first assertion only. ACK_V / RESULT_V_IN likewise.
    - Both seen, including both ACKs arriving in the same cycle -> DONE.
    - Counter increments each WAIT cycle; counter == TMO_MAX with a chain still pending -> ERR.
    - If both seen and timeout occur in the same cycle, DONE wins.
  - DONE: RESULT_VALID = 1 for one cycle -> IDLE.
  - ERR: TIMEOUT = 1 for one cycle. RESULT_I/RESULT_V keep the values captured so far; no RESULT_VALID. Then -> CLR, which re-runs the same held operands. At most one retry per sample: a second timeout -> IDLE, dropping the sample.
- ACK handling:
  - ACK high in CLR or START is ignored; ACKs may be sticky from the previous run.
  - ACK in IDLE is ignored.
- Latency (ACK returns k cycles after BEGIN): accept edge T, RST_FSM_OUT at T+1, BEGIN at T+2, RESULT_VALID at T+2+k+1.
- RST_N asserted mid-run aborts immediately: no RESULT_VALID, no TIMEOUT.

Optional Feature:
- Macro: LN_SEQ_STATS_EN.
- Defined:
  - Adds outputs SAMPLE_CNT[15:0] and TMO_CNT[15:0].
  - SAMPLE_CNT increments on each DONE; TMO_CNT increments on each ERR.
  - Both saturate at 16'hFFFF and are cleared by RST_N.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package ln_norm_pkg:
  - State encoding: IDLE=0, CLR=1, START=2, WAIT=3, DONE=4, ERR=5, 3 bits.
  - Default P and TMO_MAX localparams.
- One natural sub-module, ln_seq_watchdog: loadable counter with clear, enable and expire flag, reused by other sequencers.

Test Plan:
- Nominal: I_IN=32'h40A00000, V_IN=32'h41200000. ACK_I after 10 cycles with RESULT_I_IN=32'h00050000, ACK_V after 6 cycles with 32'h000A0000 -> RESULT_VALID exactly one cycle at accept+13, carrying both captured values; BEGIN_V drops before BEGIN_I.
- Simultaneous ACKs in one WAIT cycle -> DONE next cycle; RESULT_VALID pulses once.
- ACK_V never asserted, TMO_MAX=20 -> TIMEOUT pulse, RST_FSM_OUT re-pulse and the same operands replayed. Second expiry -> IDLE with SAMPLE_READY=1 and no RESULT_VALID.
- Back-to-back samples with SAMPLE_VALID held high -> second accept only in the IDLE cycle after DONE. Sticky ACK_I from run 1 is ignored until WAIT of run 2.
- RST_N pulsed low mid-WAIT -> all outputs 0, SAMPLE_READY=1 asynchronously; no stray strobes after release.
- With LN_SEQ_STATS_EN: 3 good runs + 1 double-timeout -> SAMPLE_CNT=3, TMO_CNT=2.
